// File: rtl/regfile_write_arbiter.sv
// Writeback arbiter for the single register-file write port, plus a 16-entry busy scoreboard.
// Define REGFILE_ARB_RR_EN for round-robin arbitration; fixed priority mem > link > alu otherwise.
module regfile_write_arbiter #(
    parameter int DATA_W  = 32,
    parameter int NUM_REQ = 3
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              mem_valid,
    input  logic [3:0]        mem_reg,
    input  logic [DATA_W-1:0] mem_data,
    output logic              mem_ready,
    input  logic              link_valid,
    input  logic [DATA_W-1:0] link_data,
    output logic              link_ready,
    input  logic              alu_valid,
    input  logic [3:0]        alu_reg,
    input  logic [DATA_W-1:0] alu_data,
    output logic              alu_ready,
    output logic              rf_we,
    output logic [3:0]        rf_waddr,
    output logic [DATA_W-1:0] rf_wdata,
    output logic              pc_write,
    input  logic              sb_set,
    input  logic [3:0]        sb_reg,
    input  logic              rd1_en,
    input  logic [3:0]        rd1_reg,
    input  logic              rd2_en,
    input  logic [3:0]        rd2_reg,
    output logic              stall
);

    localparam logic [3:0] LINK_REG = 4'hE;
    localparam logic [3:0] PC_REG   = 4'hF;

    logic [NUM_REQ-1:0] w_req;
    logic [NUM_REQ-1:0] w_gnt;
    logic               w_any_gnt;
    logic [3:0]         w_dest;
    logic [DATA_W-1:0]  w_data;

    logic               r_rf_we;
    logic [3:0]         r_rf_waddr;
    logic [DATA_W-1:0]  r_rf_wdata;
    logic               r_pc_write;
    logic [15:0]        r_busy;
    logic [15:0]        w_busy_set;
    logic [15:0]        w_busy_clr;

    // Bit 0 = mem, bit 1 = link, bit 2 = alu throughout.
    assign w_req = {alu_valid, link_valid, mem_valid};

`ifdef REGFILE_ARB_RR_EN
    logic [1:0] r_rr_ptr;
    logic [1:0] w_rr_ptr_next;

    // The pointer names the requester with highest priority this cycle.
    always_comb begin
        w_gnt = '0;
        case (r_rr_ptr)
            2'd1: begin
                if (w_req[1])      w_gnt[1] = 1'b1;
                else if (w_req[2]) w_gnt[2] = 1'b1;
                else if (w_req[0]) w_gnt[0] = 1'b1;
            end
            2'd2: begin
                if (w_req[2])      w_gnt[2] = 1'b1;
                else if (w_req[0]) w_gnt[0] = 1'b1;
                else if (w_req[1]) w_gnt[1] = 1'b1;
            end
            default: begin
                if (w_req[0])      w_gnt[0] = 1'b1;
                else if (w_req[1]) w_gnt[1] = 1'b1;
                else if (w_req[2]) w_gnt[2] = 1'b1;
            end
        endcase
        if (reset) begin
            w_gnt = '0;
        end
    end

    always_comb begin
        w_rr_ptr_next = r_rr_ptr;
        if (w_gnt[0])      w_rr_ptr_next = 2'd1;
        else if (w_gnt[1]) w_rr_ptr_next = 2'd2;
        else if (w_gnt[2]) w_rr_ptr_next = 2'd0;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_rr_ptr <= 2'd0;
        end else begin
            r_rr_ptr <= w_rr_ptr_next;
        end
    end
`else
    always_comb begin
        w_gnt = '0;
        if (!reset) begin
            if (w_req[0])      w_gnt[0] = 1'b1;
            else if (w_req[1]) w_gnt[1] = 1'b1;
            else if (w_req[2]) w_gnt[2] = 1'b1;
        end
    end
`endif

    assign mem_ready  = w_gnt[0];
    assign link_ready = w_gnt[1];
    assign alu_ready  = w_gnt[2];
    assign w_any_gnt  = |w_gnt;

    always_comb begin
        w_dest = alu_reg;
        w_data = alu_data;
        if (w_gnt[0]) begin
            w_dest = mem_reg;
            w_data = mem_data;
        end else if (w_gnt[1]) begin
            w_dest = LINK_REG;
            w_data = link_data;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_rf_we    <= 1'b0;
            r_rf_waddr <= '0;
            r_rf_wdata <= '0;
            r_pc_write <= 1'b0;
        end else begin
            r_rf_we    <= w_any_gnt;
            r_pc_write <= w_any_gnt && (w_dest == PC_REG);
            if (w_any_gnt) begin
                r_rf_waddr <= w_dest;
                r_rf_wdata <= w_data;
            end
        end
    end

    // Set beats clear so a freshly issued producer keeps ownership; R15 never goes busy.
    generate
        for (genvar gi = 0; gi < 16; gi++) begin : g_busy
            assign w_busy_clr[gi] = w_any_gnt && (w_dest == 4'(gi));
            if (gi == 15) begin : g_pc
                assign w_busy_set[gi] = 1'b0;
            end else begin : g_gpr
                assign w_busy_set[gi] = sb_set && (sb_reg == 4'(gi));
            end

            always_ff @(posedge clk) begin
                if (reset) begin
                    r_busy[gi] <= 1'b0;
                end else if (w_busy_set[gi]) begin
                    r_busy[gi] <= 1'b1;
                end else if (w_busy_clr[gi]) begin
                    r_busy[gi] <= 1'b0;
                end
            end
        end
    endgenerate

    assign stall    = (rd1_en && r_busy[rd1_reg]) || (rd2_en && r_busy[rd2_reg]);
    assign rf_we    = r_rf_we;
    assign rf_waddr = r_rf_waddr;
    assign rf_wdata = r_rf_wdata;
    assign pc_write = r_pc_write;

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Bench for regfile_write_arbiter: directed steps then random traffic against a behavioural model.
// Build with REGFILE_ARB_RR_EN defined to check the round-robin variant.
module tb_regfile_write_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        mem_valid, link_valid, alu_valid;
    logic [3:0]  mem_reg, alu_reg;
    logic [31:0] mem_data, link_data, alu_data;
    logic        mem_ready, link_ready, alu_ready;
    logic        rf_we, pc_write;
    logic [3:0]  rf_waddr;
    logic [31:0] rf_wdata;
    logic        sb_set, rd1_en, rd2_en;
    logic [3:0]  sb_reg, rd1_reg, rd2_reg;
    logic        stall;

    always #5 clk = ~clk;

    regfile_write_arbiter #(.DATA_W(32), .NUM_REQ(3)) dut (
        .clk(clk), .reset(reset),
        .mem_valid(mem_valid), .mem_reg(mem_reg), .mem_data(mem_data), .mem_ready(mem_ready),
        .link_valid(link_valid), .link_data(link_data), .link_ready(link_ready),
        .alu_valid(alu_valid), .alu_reg(alu_reg), .alu_data(alu_data), .alu_ready(alu_ready),
        .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata), .pc_write(pc_write),
        .sb_set(sb_set), .sb_reg(sb_reg),
        .rd1_en(rd1_en), .rd1_reg(rd1_reg), .rd2_en(rd2_en), .rd2_reg(rd2_reg),
        .stall(stall)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state: index 0 = mem, 1 = link, 2 = alu.
    bit          m_busy [16];
    bit          m_we;
    logic [3:0]  m_waddr;
    logic [31:0] m_wdata;
    bit          m_pc;
    int          m_ptr;
    int          m_gnt;
    logic        s_stall;
    logic [2:0]  s_ready;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic int model_grant();
        bit v [3];
        v[0] = mem_valid;
        v[1] = link_valid;
        v[2] = alu_valid;
        if (reset) return -1;
`ifdef REGFILE_ARB_RR_EN
        for (int k = 0; k < 3; k++) begin
            if (v[(m_ptr + k) % 3]) return (m_ptr + k) % 3;
        end
`else
        for (int i = 0; i < 3; i++) begin
            if (v[i]) return i;
        end
`endif
        return -1;
    endfunction

    // One clock: inputs already driven after the falling edge; sample comb outputs,
    // cross the rising edge, update the model and compare registered outputs.
    task automatic cycle(input bit do_chk);
        int          g;
        logic        exp_stall;
        logic [2:0]  exp_ready;
        logic [3:0]  dest;
        logic [31:0] data;
        #1;
        g         = model_grant();
        m_gnt     = g;
        exp_stall = (rd1_en && m_busy[rd1_reg]) || (rd2_en && m_busy[rd2_reg]);
        exp_ready = (g >= 0) ? (3'b001 << g) : 3'b000;
        s_stall   = stall;
        s_ready   = {alu_ready, link_ready, mem_ready};
        if (do_chk) begin
            check("ready", {29'd0, s_ready}, {29'd0, exp_ready});
            check("stall", {31'd0, s_stall}, {31'd0, exp_stall});
        end
        dest = (g == 0) ? mem_reg : (g == 1) ? 4'd14 : alu_reg;
        data = (g == 0) ? mem_data : (g == 1) ? link_data : alu_data;
        @(posedge clk);
        #1;
        if (reset) begin
            m_we = 0; m_waddr = 0; m_wdata = 0; m_pc = 0; m_ptr = 0;
            foreach (m_busy[i]) m_busy[i] = 0;
        end else begin
            m_we = (g >= 0);
            m_pc = (g >= 0) && (dest == 4'd15);
            if (g >= 0) begin
                m_waddr = dest;
                m_wdata = data;
                m_busy[dest] = 0;
                m_ptr = (g + 1) % 3;
            end
            if (sb_set && sb_reg != 4'd15) m_busy[sb_reg] = 1;
        end
        if (do_chk) begin
            check("rf_we", {31'd0, rf_we}, {31'd0, m_we});
            check("rf_waddr", {28'd0, rf_waddr}, {28'd0, m_waddr});
            check("rf_wdata", rf_wdata, m_wdata);
            check("pc_write", {31'd0, pc_write}, {31'd0, m_pc});
        end
        @(negedge clk);
    endtask

    task automatic release_granted();
        if (m_gnt == 0) mem_valid = 0;
        if (m_gnt == 1) link_valid = 0;
        if (m_gnt == 2) alu_valid = 0;
    endtask

    initial begin
        int alu_wait;
        reset = 1; sb_set = 0; sb_reg = 0;
        rd1_en = 0; rd1_reg = 0; rd2_en = 0; rd2_reg = 0;
        mem_valid = 1; mem_reg = 4'd1; mem_data = 32'h1;
        link_valid = 1; link_data = 32'h2;
        alu_valid = 1; alu_reg = 4'd2; alu_data = 32'h3;
        m_ptr = 0; m_gnt = -1; m_we = 0; m_pc = 0; m_waddr = 0; m_wdata = 0;
        foreach (m_busy[i]) m_busy[i] = 0;

        // Reset with every requester asking.
        cycle(0);
        cycle(1);
        check("reset_ready", {29'd0, s_ready}, 32'd0);
        check("reset_rf_we", {31'd0, rf_we}, 32'd0);

        // First transfer after reset.
        reset = 0; mem_valid = 0; link_valid = 0;
        alu_valid = 1; alu_reg = 4'd8; alu_data = 32'hAAAAAAAA;
        cycle(1);
        check("alu_first_ready", {31'd0, s_ready[2]}, 32'd1);
        check("alu_first_we", {31'd0, rf_we}, 32'd1);
        check("alu_first_addr", {28'd0, rf_waddr}, 32'd8);
        check("alu_first_data", rf_wdata, 32'hAAAAAAAA);
        check("alu_first_pc", {31'd0, pc_write}, 32'd0);
        alu_valid = 0;
        cycle(1);

        // Three-way contention, each held until accepted.
        mem_valid = 1; mem_reg = 4'd0; mem_data = 32'hCCCCCCCC;
        link_valid = 1; link_data = 32'h00000104;
        alu_valid = 1; alu_reg = 4'd3; alu_data = 32'h11111111;
        cycle(1); release_granted();
        check("contend_1st", {28'd0, rf_waddr}, 32'd0);
        cycle(1); release_granted();
        check("contend_2nd", {28'd0, rf_waddr}, 32'd14);
        cycle(1); release_granted();
        check("contend_3rd", {28'd0, rf_waddr}, 32'd3);
        check("contend_3rd_we", {31'd0, rf_we}, 32'd1);
        cycle(1);

        // mem and alu always valid; round-robin must bound the alu wait.
        alu_wait = 0;
        mem_valid = 1; mem_reg = 4'd1; alu_valid = 1; alu_reg = 4'd2;
        for (int i = 0; i < 10; i++) begin
            mem_data = $urandom; alu_data = $urandom;
            cycle(1);
            if (s_ready[2]) alu_wait = 0; else alu_wait++;
`ifdef REGFILE_ARB_RR_EN
            check("alu_wait_bound", alu_wait, (alu_wait <= 2) ? alu_wait : 32'd2);
`endif
        end
        mem_valid = 0; alu_valid = 0;
        cycle(1);

        // Scoreboard: set, stall, clear by write.
        sb_set = 1; sb_reg = 4'd5;
        cycle(1);
        sb_set = 0; rd1_en = 1; rd1_reg = 4'd5;
        cycle(1);
        check("sb_stall_set", {31'd0, s_stall}, 32'd1);
        alu_valid = 1; alu_reg = 4'd5; alu_data = 32'h55;
        cycle(1);
        check("sb_stall_accept", {31'd0, s_stall}, 32'd1);
        alu_valid = 0;
        cycle(1);
        check("sb_stall_cleared", {31'd0, s_stall}, 32'd0);

        // Same-cycle set and grant: set wins.
        sb_set = 1; alu_valid = 1; alu_data = 32'h56;
        cycle(1);
        sb_set = 0; alu_valid = 0;
        cycle(1);
        check("sb_set_wins", {31'd0, s_stall}, 32'd1);
        alu_valid = 1; alu_data = 32'h57;
        cycle(1);
        alu_valid = 0; rd1_en = 0;
        cycle(1);

        // PC write.
        alu_valid = 1; alu_reg = 4'd15; alu_data = 32'h00000200;
        cycle(1);
        alu_valid = 0;
        check("pc_we", {31'd0, rf_we}, 32'd1);
        check("pc_addr", {28'd0, rf_waddr}, 32'd15);
        check("pc_write_hi", {31'd0, pc_write}, 32'd1);
        cycle(1);
        check("pc_write_lo", {31'd0, pc_write}, 32'd0);
        sb_set = 1; sb_reg = 4'd15;
        cycle(1);
        sb_set = 0; rd2_en = 1; rd2_reg = 4'd15;
        cycle(1);
        check("pc_no_stall", {31'd0, s_stall}, 32'd0);

        // Reset in the middle of traffic.
        sb_set = 1; sb_reg = 4'd2;
        cycle(1);
        sb_reg = 4'd7;
        cycle(1);
        sb_set = 0; rd1_en = 1; rd1_reg = 4'd2; rd2_en = 1; rd2_reg = 4'd7;
        mem_valid = 1; mem_reg = 4'd9; mem_data = 32'h99;
        reset = 1;
        cycle(1);
        check("midrst_we", {31'd0, rf_we}, 32'd0);
        reset = 0; mem_valid = 0;
        cycle(1);
        check("midrst_busy", {31'd0, s_stall}, 32'd0);
        check("midrst_we_after", {31'd0, rf_we}, 32'd0);

        // Random traffic; requesters hold until accepted.
        mem_valid = 0; link_valid = 0; alu_valid = 0;
        for (int i = 0; i < 400; i++) begin
            if (!mem_valid && $urandom_range(0, 2) != 0) begin
                mem_valid = 1; mem_reg = 4'($urandom); mem_data = $urandom;
            end
            if (!link_valid && $urandom_range(0, 3) == 0) begin
                link_valid = 1; link_data = $urandom;
            end
            if (!alu_valid && $urandom_range(0, 2) != 0) begin
                alu_valid = 1; alu_reg = 4'($urandom); alu_data = $urandom;
            end
            sb_set  = ($urandom_range(0, 2) == 0);
            sb_reg  = 4'($urandom);
            rd1_en  = 1'($urandom); rd1_reg = 4'($urandom);
            rd2_en  = 1'($urandom); rd2_reg = 4'($urandom);
            reset   = ($urandom_range(0, 99) == 0);
            cycle(1);
            release_granted();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/regfile_write_arbiter.md
# regfile_write_arbiter

- Shares the register file's single write port among three writeback requesters: memory load, branch-with-link return address, and ALU result.
- Keeps a 16-entry busy scoreboard so decode can stall reads of registers whose producer has not yet written back.
- Sits between the execute/memory stages and the register file write port (write enable, destination, data).
- Flags writes to R15 so the fetch stage can redirect the PC.

## Interface
Parameters:
- DATA_W, 32, writeback data width
- NUM_REQ, 3, requester count; fixed, documented for the verification bench only

Ports:
- clk  in  1  clock, rising edge
- reset  in  1  synchronous, active-high
- mem_valid  in  1  load result available
- mem_reg  in  4  load destination register
- mem_data  in  DATA_W  load data
- mem_ready  out  1  load request accepted this cycle
- link_valid  in  1  BL return-address write request; destination is always R14
- link_data  in  DATA_W  return address
- link_ready  out  1  link request accepted this cycle
- alu_valid  in  1  ALU result available
- alu_reg  in  4  ALU destination register
- alu_data  in  DATA_W  ALU result
- alu_ready  out  1  ALU request accepted this cycle
- rf_we  out  1  register-file write enable (registered)
- rf_waddr  out  4  register-file write destination (registered)
- rf_wdata  out  DATA_W  register-file write data (registered)
- pc_write  out  1  rf_we with rf_waddr == 4'hF (registered)
- sb_set  in  1  issue stage claims a destination
- sb_reg  in  4  claimed register
- rd1_en, rd2_en  in  1 each  read-port usage by the instruction in decode
- rd1_reg, rd2_reg  in  4 each  read addresses
- stall  out  1  decode must hold

## Operation
Arbitration:
- At most one request is granted per cycle.
- A request transfers when valid && ready are both high in the same cycle.
- ready is combinational from the valids and the arbiter state; ready never asserts without its own valid.
- Default order is fixed priority: mem > link > alu.
- A requester holds valid, reg and data stable until accepted; losing requesters wait with no drop and no reorder.
- The register file always accepts, so there is no backpressure from the write port.

Output register:
- The granted request is loaded into rf_waddr/rf_wdata with rf_we = 1 on the next edge.
- Link grants load rf_waddr = 4'hE.
- With no grant, rf_we = 0; rf_waddr/rf_wdata hold their previous values.
- pc_write = 1 in exactly the cycles where rf_we = 1 and rf_waddr = 15.

Scoreboard (busy[15:0]):
- sb_set sets busy[sb_reg] at the next edge.
- A granted request clears busy[dest] at the same edge its write is loaded into the output register.
- If a set and a clear target the same register in the same cycle, the set wins (a new producer owns the register).
- busy[15] is never set; sb_set with sb_reg = 15 is ignored, because PC reads never stall.
- stall = (rd1_en && busy[rd1_reg]) || (rd2_en && busy[rd2_reg]); purely combinational from current busy.
- There is no bypass: a register being granted this cycle still stalls this cycle.

## Timing
- Reset values: rf_we 0, rf_waddr 0, rf_wdata 0, pc_write 0, busy all 0, round-robin pointer = mem.
- All ready outputs are 0 during reset; stall is 0 after reset.
- Latency is 1 cycle from accept edge to rf_we high; sustained throughput is one write per cycle.
- After a clear, stall for that register drops in the cycle following the accept edge, the same cycle rf_we is high.
- Reset asserted mid-stream: pending requests are neither accepted nor written, and busy is cleared. Requesters must re-present after reset deasserts.
- Simultaneous valids on all three requesters: one grant per cycle; all three are written over three consecutive cycles.

## Configuration
- REGFILE_ARB_RR_EN defined:
  - Round-robin arbitration over the order mem -> link -> alu.
  - The pointer advances to the requester after the one granted.
  - No pointer change on idle cycles.
  - Worst-case wait is 2 cycles.
- REGFILE_ARB_RR_EN undefined:
  - Fixed priority mem > link > alu; no pointer state.
  - ALU can starve while mem or link stay valid.

## Test plan
- Reset/idle:
  - Stimulus: reset for 2 cycles with all valids high.
  - Required: all ready 0, rf_we 0, busy 0.
  - Then release with only alu_valid, reg 8, data 32'hAAAAAAAA.
  - Required: alu_ready the first cycle; next cycle rf_we=1, rf_waddr=8, rf_wdata=32'hAAAAAAAA, pc_write=0.
- Three-way contention:
  - Stimulus: mem(reg 0, 32'hCCCCCCCC), link(32'h00000104) and alu(reg 3, 32'h11111111) all valid and held.
  - Required without the macro: writes R0, R14, R3 on three consecutive cycles.
  - Required with the macro: same order from reset, then rotation continues.
- Starvation (with macro):
  - Stimulus: mem and alu continuously valid.
  - Required: grants alternate mem/alu, and alu is never waiting more than 2 cycles.
- Scoreboard:
  - sb_set reg 5, then rd1_en/rd1_reg=5: stall=1.
  - ALU write to R5 accepted: stall=1 in the accept cycle, 0 the cycle after.
  - Same-cycle sb_set reg 5 and grant to R5: busy[5] remains 1.
- PC write:
  - Stimulus: alu reg 15, data 32'h00000200.
  - Required: rf_we=1, rf_waddr=15, pc_write=1 for exactly one cycle.
  - sb_set reg 15 followed by rd2_reg=15 gives stall=0.
- Reset mid-operation:
  - Stimulus: set busy on R2 and R7, hold mem_valid, assert reset for 1 cycle.
  - Required: no rf_we in the cycle after reset, and busy is all 0.
